// File: rtl/pulse_sched_if.sv
// Requester/engine-facing bundle of the pulse scheduler: request levels, counts,
// grant/completion and the single-bit engine link.
interface pulse_sched_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 3
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] len;
    logic [N_REQ-1:0]       grant;
    logic                   done;
    logic                   err;
    logic                   FSM_in;
    logic                   FSM_out;

    modport master (
        output req, len, FSM_out,
        input  grant, done, err, FSM_in
    );

    modport slave (
        input  req, len, FSM_out,
        output grant, done, err, FSM_in
    );
endinterface

// File: rtl/pulse_sched.sv
// Round-robin scheduler sharing one pulse-counting engine between N_REQ requesters:
// plays the winner's count as spaced pulses, then waits (bounded) for engine completion.
module pulse_sched #(
    parameter int N_REQ   = 4,
    parameter int CNT_W   = 3,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 16
) (
    input logic          Clk,
    input logic          rst,
    pulse_sched_if.slave bus
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int GAP_W = $clog2(GAP + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_PULSE, S_GAP, S_WAIT, S_DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] winner;
    logic [CNT_W-1:0] remaining;
    logic [GAP_W-1:0] gap_cnt;
    logic [TO_W-1:0]  wait_cnt;
    logic [N_REQ-1:0] grant_q;
    logic             done_q;
    logic             err_q;
    logic             fsm_in_q;

    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic [CNT_W-1:0] pick_len;

    // First active request at or after the pointer, wrapping around.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        pick_len = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!pick_vld && bus.req[(int'(ptr) + i) % N_REQ]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'((int'(ptr) + i) % N_REQ);
                pick_len = bus.len[((int'(ptr) + i) % N_REQ) * CNT_W +: CNT_W];
            end
        end
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            winner    <= '0;
            remaining <= '0;
            gap_cnt   <= '0;
            wait_cnt  <= '0;
            grant_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            fsm_in_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        grant_q   <= N_REQ'(1) << pick_idx;
                        winner    <= pick_idx;
                        remaining <= pick_len;
                        if (pick_len == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state    <= S_PULSE;
                            fsm_in_q <= 1'b1;
                        end
                    end
                end
                S_PULSE: begin
                    fsm_in_q  <= 1'b0;
                    remaining <= remaining - CNT_W'(1);
                    if (remaining != CNT_W'(1)) begin
                        state   <= S_GAP;
                        gap_cnt <= '0;
                    end else begin
                        state    <= S_WAIT;
                        wait_cnt <= '0;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_W'(GAP - 1)) begin
                        state    <= S_PULSE;
                        fsm_in_q <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                // Engine completion wins over a timeout expiring in the same cycle.
                S_WAIT: begin
                    if (bus.FSM_out) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                        err_q  <= 1'b0;
                    end else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    grant_q <= '0;
                    ptr     <= (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.grant  = grant_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.FSM_in = fsm_in_q;
endmodule

// File: tb/tb_pulse_sched.sv
// Bench for pulse_sched: directed scenarios plus random transactions checked cycle by
// cycle against a transaction-level timing model.
module tb_pulse_sched;
    localparam int N_REQ   = 4;
    localparam int CNT_W   = 3;
    localparam int GAP     = 1;
    localparam int TIMEOUT = 16;
    localparam int OBS_W   = N_REQ + 3;

    logic Clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    int   ptr_m;

    pulse_sched_if #(.N_REQ(N_REQ), .CNT_W(CNT_W)) bus ();

    pulse_sched #(
        .N_REQ(N_REQ), .CNT_W(CNT_W), .GAP(GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .Clk (Clk),
        .rst (rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [OBS_W-1:0] observed();
        return {bus.grant, bus.done, bus.err, bus.FSM_in};
    endfunction

    function automatic logic [N_REQ*CNT_W-1:0] pack(input int l3, input int l2, input int l1, input int l0);
        return {CNT_W'(l3), CNT_W'(l2), CNT_W'(l1), CNT_W'(l0)};
    endfunction

    task automatic check(input string tag, input int cyc, input logic [OBS_W-1:0] obs,
                         input logic [OBS_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc %0d: observed grant/done/err/in=%b expected %b", tag, cyc, obs, exp);
        end
    endtask

    // Entered at the falling edge of an IDLE cycle; returns at the falling edge of the
    // IDLE cycle that follows DONE. delay<0 or >=TIMEOUT means the engine never answers.
    task automatic run_txn(input string tag, input logic [N_REQ-1:0] r,
                           input logic [N_REQ*CNT_W-1:0] l, input int delay,
                           input bit noise, input bit drop);
        int win, len_w, ws, d_off;
        bit to;
        logic [N_REQ-1:0] g;
        logic [OBS_W-1:0] exp;
        win = -1;
        for (int i = 0; i < N_REQ; i++)
            if (win < 0 && r[(ptr_m + i) % N_REQ]) win = (ptr_m + i) % N_REQ;
        len_w = int'(l[win*CNT_W +: CNT_W]);
        g = '0;
        g[win] = 1'b1;
        to = 1'b0;
        ws = 0;
        if (len_w == 0) begin
            d_off = 0;
        end else begin
            ws = (len_w - 1) * (GAP + 1) + 1;
            if (delay >= 0 && delay < TIMEOUT) d_off = ws + delay + 1;
            else begin
                d_off = ws + TIMEOUT;
                to = 1'b1;
            end
        end
        bus.req = r;
        bus.len = l;
        bus.FSM_out = 1'b0;
        for (int o = 0; o <= d_off + 1; o++) begin
            @(negedge Clk);
            exp = {(o <= d_off) ? g : '0, o == d_off, o == d_off && to,
                   len_w > 0 && o < ws && (o % (GAP + 1)) == 0};
            check(tag, o, observed(), exp);
            bus.FSM_out = (!to && len_w > 0 && o == ws + delay) ||
                          (noise && o < ws && (o % (GAP + 1)) != 0);
            if (drop && o == 1) bus.req = '0;
        end
        bus.FSM_out = 1'b0;
        bus.req = '0;
        ptr_m = (win + 1) % N_REQ;
    endtask

    initial begin
        logic [N_REQ-1:0] r;
        logic [N_REQ*CNT_W-1:0] l;
        int dly;
        n_cmp = 0;
        n_fail = 0;
        ptr_m = 0;
        rst = 1'b1;
        bus.req = 4'b1111;
        bus.len = pack(1, 2, 3, 4);
        bus.FSM_out = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            check("reset_hold", i, observed(), '0);
        end
        rst = 1'b0;
        bus.req = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            check("idle_noreq", i, observed(), '0);
        end

        // Reset asserted mid-PULSE clears outputs without waiting for a clock edge.
        bus.req = 4'b1000;
        bus.len = pack(5, 0, 0, 0);
        @(negedge Clk);
        check("pre_async_rst", 0, observed(), {4'b1000, 1'b0, 1'b0, 1'b1});
        #2 rst = 1'b1;
        #1 check("async_rst", 0, observed(), '0);
        bus.req = '0;
        @(negedge Clk);
        rst = 1'b0;
        ptr_m = 0;

        for (int i = 0; i < 6; i++)
            run_txn("round_robin", 4'b1011, pack(1, 1, 1, 1), 0, 1'b0, 1'b0);
        run_txn("single_req2", 4'b0100, pack(0, 3, 0, 0), 2, 1'b0, 1'b0);
        run_txn("timeout", 4'b0001, pack(0, 0, 0, 2), -1, 1'b0, 1'b0);
        run_txn("len_zero", 4'b0010, pack(0, 0, 0, 0), 0, 1'b0, 1'b0);
        run_txn("len_max", 4'b0001, pack(0, 0, 0, 7), 5, 1'b0, 1'b0);
        run_txn("ignored_inputs", 4'b0010, pack(0, 0, 4, 0), 3, 1'b1, 1'b1);

        for (int t = 0; t < 40; t++) begin
            r = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            l = (N_REQ*CNT_W)'($urandom);
            dly = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TIMEOUT - 1));
            run_txn("random", r, l, dly, 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
